// File: rtl/branch_resolve_unit_pkg.sv
// Shared front-end / back-end branch definitions.
//   BR_PC_W     : default program-counter width
//   br_type_e   : branch type encoding as seen by the front end
//   br_entry_t  : speculative branch record at the default PC width
//   bru_state_e : resolve-unit control states
package branch_resolve_unit_pkg;

  localparam int unsigned BR_PC_W = 16;

  typedef enum logic [1:0] {
    BR_CC = 2'b00,
    BR_B  = 2'b01,
    BR_BL = 2'b10,
    BR_BX = 2'b11
  } br_type_e;

  typedef struct packed {
    logic               taken;
    logic               is_bx;
    logic [BR_PC_W-1:0] target_pc;
    logic [BR_PC_W-1:0] fall_pc;
  } br_entry_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// FE/EX <-> branch resolve unit bundle.
//   spec_*     : speculative branch issue from the front end (spec_ready_o back)
//   resolve_*  : actual outcome of the oldest branch from execute
//   redirect_*, flush_o : registered correction pulse to the front end
//   count_o, branch_cnt_o, mispred_cnt_o, error_o : status
// master = FE/EX side, slave = resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) ();
  logic                     spec_v_i;
  logic                     spec_ready_o;
  logic                     spec_taken_i;
  logic                     spec_is_bx_i;
  logic [PC_W-1:0]          spec_target_pc_i;
  logic [PC_W-1:0]          spec_fall_pc_i;
  logic                     resolve_v_i;
  logic                     resolve_taken_i;
  logic [PC_W-1:0]          resolve_target_i;
  logic                     redirect_v_o;
  logic [PC_W-1:0]          redirect_pc_o;
  logic                     flush_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic [CNT_W-1:0]         branch_cnt_o;
  logic [CNT_W-1:0]         mispred_cnt_o;
  logic                     error_o;

  modport slave (
    input  spec_v_i, spec_taken_i, spec_is_bx_i, spec_target_pc_i, spec_fall_pc_i,
    input  resolve_v_i, resolve_taken_i, resolve_target_i,
    output spec_ready_o, redirect_v_o, redirect_pc_o, flush_o,
    output count_o, branch_cnt_o, mispred_cnt_o, error_o
  );

  modport master (
    output spec_v_i, spec_taken_i, spec_is_bx_i, spec_target_pc_i, spec_fall_pc_i,
    output resolve_v_i, resolve_taken_i, resolve_target_i,
    input  spec_ready_o, redirect_v_o, redirect_pc_o, flush_o,
    input  count_o, branch_cnt_o, mispred_cnt_o, error_o
  );
endinterface

// File: rtl/branch_spec_fifo.sv
// Generic pointer-based FIFO with synchronous clear and occupancy count.
//   clk_i, reset_i : clock, async active-high reset
//   clr_i          : empty the queue (overrides push/pop)
//   push_i/din_i   : write (ignored when full)
//   pop_i/dout_o   : read head (ignored when empty); dout_o shows head
//   count_o, full_o, empty_o : occupancy
module branch_spec_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_head;
  logic [AW:0]  r_tail;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign count_o = r_tail - r_head;
  assign full_o  = (count_o == FULLC);
  assign empty_o = (r_head == r_tail);
  assign dout_o  = r_mem[r_head[AW-1:0]];
  assign w_push  = push_i && !full_o && !clr_i;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (clr_i) begin
      r_head <= r_tail;
    end else begin
      if (w_push) r_tail <= r_tail + ONE;
      if (w_pop)  r_head <= r_head + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_tail[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Back-end branch resolve unit: queues speculative branches issued by the
// front end, compares the oldest against the execute-stage outcome, and on a
// mispredict emits a registered one-cycle redirect + flush while clearing all
// younger (wrong-path) entries. Keeps saturating branch/mispredict counters.
//   clk_i, reset_i : clock, async active-high reset
//   bus (slave)    : spec issue, resolve, redirect/flush and status signals
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned PC_W  = BR_PC_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  branch_resolve_unit_if.slave  bus
);
  typedef struct packed {
    logic            taken;
    logic            is_bx;
    logic [PC_W-1:0] target_pc;
    logic [PC_W-1:0] fall_pc;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bru_state_e             r_state;
  logic                   r_redirect;
  logic                   r_flush;
  logic [PC_W-1:0]        r_redirect_pc;
  logic [CNT_W-1:0]       r_branch_cnt;
  logic [CNT_W-1:0]       r_mispred_cnt;
  logic                   r_error;

  entry_t                 w_push_entry;
  entry_t                 w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_run;
  logic                   w_push;
  logic                   w_resolve;
  logic                   w_wrong;
  logic                   w_mispred;
  logic [PC_W-1:0]        w_correct_pc;

  assign w_run     = (r_state == ST_RUN);
  assign w_push    = w_run && bus.spec_v_i && !w_full;
  assign w_resolve = w_run && bus.resolve_v_i && !w_empty;
  assign w_mispred = w_resolve && w_wrong;

  always_comb begin
    w_push_entry           = '0;
    w_push_entry.taken     = bus.spec_taken_i;
    w_push_entry.is_bx     = bus.spec_is_bx_i;
    w_push_entry.target_pc = bus.spec_target_pc_i;
    w_push_entry.fall_pc   = bus.spec_fall_pc_i;
  end

  // BX targets are only known at execute, so a taken BX always needs a redirect.
  always_comb begin
    w_wrong      = 1'b0;
    w_correct_pc = w_head.fall_pc;
    if (w_head.is_bx) begin
      w_wrong      = bus.resolve_taken_i ||
                     (w_head.taken && (w_head.target_pc != bus.resolve_target_i));
      w_correct_pc = bus.resolve_taken_i ? bus.resolve_target_i : w_head.fall_pc;
    end else begin
      w_wrong      = (w_head.taken != bus.resolve_taken_i);
      w_correct_pc = bus.resolve_taken_i ? w_head.target_pc : w_head.fall_pc;
    end
  end

  // Clear wins over a same-cycle push: that entry is already wrong-path.
  branch_spec_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (w_mispred),
    .push_i  (w_push),
    .pop_i   (w_resolve),
    .din_i   (w_push_entry),
    .dout_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ST_RUN;
      r_redirect    <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mispred) begin
            r_state       <= ST_REDIRECT;
            r_redirect    <= 1'b1;
            r_flush       <= 1'b1;
            r_redirect_pc <= w_correct_pc;
          end
        end
        ST_REDIRECT: begin
          r_state    <= ST_RUN;
          r_redirect <= 1'b0;
          r_flush    <= 1'b0;
        end
        default: begin
          r_state    <= ST_RUN;
          r_redirect <= 1'b0;
          r_flush    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_resolve && (r_branch_cnt != '1))  r_branch_cnt  <= r_branch_cnt + CNT_ONE;
      if (w_mispred && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      if (w_run && bus.resolve_v_i && w_empty) r_error <= 1'b1;
    end
  end

  assign bus.spec_ready_o  = !w_full;
  assign bus.redirect_v_o  = r_redirect;
  assign bus.flush_o       = r_flush;
  assign bus.redirect_pc_o = r_redirect_pc;
  assign bus.count_o       = w_count;
  assign bus.branch_cnt_o  = r_branch_cnt;
  assign bus.mispred_cnt_o = r_mispred_cnt;
  assign bus.error_o       = r_error;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int unsigned PC_W  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 5;

  logic clk;
  logic reset_i;
  int   n_total = 0;
  int   n_fail  = 0;

  branch_resolve_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spec(input logic v, input logic t, input logic bx,
                          input logic [15:0] tgt, input logic [15:0] fall);
    bus.spec_v_i         = v;
    bus.spec_taken_i     = t;
    bus.spec_is_bx_i     = bx;
    bus.spec_target_pc_i = tgt;
    bus.spec_fall_pc_i   = fall;
  endtask

  task automatic set_res(input logic v, input logic t, input logic [15:0] tgt);
    bus.resolve_v_i      = v;
    bus.resolve_taken_i  = t;
    bus.resolve_target_i = tgt;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_count"},    32'(bus.count_o), 0);
    chk({pfx, "_ready"},    32'(bus.spec_ready_o), 1);
    chk({pfx, "_redir"},    32'(bus.redirect_v_o), 0);
    chk({pfx, "_pc"},       32'(bus.redirect_pc_o), 0);
    chk({pfx, "_flush"},    32'(bus.flush_o), 0);
    chk({pfx, "_brcnt"},    32'(bus.branch_cnt_o), 0);
    chk({pfx, "_mpcnt"},    32'(bus.mispred_cnt_o), 0);
    chk({pfx, "_error"},    32'(bus.error_o), 0);
  endtask

  initial begin
    reset_i = 1'b1;
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(0, 0, 16'h0);
    tick();
    tick();
    chk_reset_state("rst");
    #3 reset_i = 1'b0;

    // Correctly predicted CC branch
    set_spec(1, 1, 0, 16'h0040, 16'h0011);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    chk("t1_count1", 32'(bus.count_o), 1);
    set_res(1, 1, 16'h0);
    tick();
    set_res(0, 0, 16'h0);
    chk("t1_count0", 32'(bus.count_o), 0);
    chk("t1_redir",  32'(bus.redirect_v_o), 0);
    chk("t1_brcnt",  32'(bus.branch_cnt_o), 1);
    chk("t1_mpcnt",  32'(bus.mispred_cnt_o), 0);

    // Predicted not-taken, actually taken
    set_spec(1, 0, 0, 16'h0080, 16'h0021);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(1, 1, 16'h0);
    tick();
    set_res(0, 0, 16'h0);
    chk("t2_redir",  32'(bus.redirect_v_o), 1);
    chk("t2_flush",  32'(bus.flush_o), 1);
    chk("t2_pc",     32'(bus.redirect_pc_o), 32'h0080);
    chk("t2_mpcnt",  32'(bus.mispred_cnt_o), 1);
    chk("t2_brcnt",  32'(bus.branch_cnt_o), 2);
    tick();
    chk("t2_redir_off", 32'(bus.redirect_v_o), 0);
    chk("t2_flush_off", 32'(bus.flush_o), 0);
    chk("t2_pc_hold",   32'(bus.redirect_pc_o), 32'h0080);

    // Fill the queue, overflow push, then flush everything
    for (int i = 0; i < 4; i++) begin
      set_spec(1, 0, 0, 16'(16'h0100 + i), 16'(16'h0200 + i));
      tick();
    end
    set_spec(0, 0, 0, 16'h0, 16'h0);
    chk("t3_full_count", 32'(bus.count_o), 4);
    chk("t3_ready0",     32'(bus.spec_ready_o), 0);
    set_spec(1, 0, 0, 16'h0999, 16'h0998);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    chk("t3_overflow_count", 32'(bus.count_o), 4);
    set_res(1, 1, 16'h0);
    tick();
    set_res(0, 0, 16'h0);
    chk("t3_count0",  32'(bus.count_o), 0);
    chk("t3_redir",   32'(bus.redirect_v_o), 1);
    chk("t3_pc",      32'(bus.redirect_pc_o), 32'h0100);
    chk("t3_ready1",  32'(bus.spec_ready_o), 1);
    chk("t3_mpcnt",   32'(bus.mispred_cnt_o), 2);
    chk("t3_brcnt",   32'(bus.branch_cnt_o), 3);
    // Issue during the redirect cycle must be dropped
    set_spec(1, 1, 0, 16'h0777, 16'h0778);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    chk("t3_redir_ignore_count", 32'(bus.count_o), 0);
    chk("t3_redir_off",          32'(bus.redirect_v_o), 0);

    // BX taken to 0x1234
    set_spec(1, 0, 1, 16'h0000, 16'h0031);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(1, 1, 16'h1234);
    tick();
    set_res(0, 0, 16'h0);
    chk("t4_redir", 32'(bus.redirect_v_o), 1);
    chk("t4_pc",    32'(bus.redirect_pc_o), 32'h1234);
    chk("t4_mpcnt", 32'(bus.mispred_cnt_o), 3);
    tick();
    // BX not taken: correct, no redirect
    set_spec(1, 0, 1, 16'h0000, 16'h0041);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(1, 0, 16'h5555);
    tick();
    set_res(0, 0, 16'h0);
    chk("t4b_redir", 32'(bus.redirect_v_o), 0);
    chk("t4b_brcnt", 32'(bus.branch_cnt_o), 5);
    chk("t4b_mpcnt", 32'(bus.mispred_cnt_o), 3);
    chk("t4b_pc_hold", 32'(bus.redirect_pc_o), 32'h1234);

    // Simultaneous push + correct resolve at count 2, wrapping pointers
    for (int k = 0; k < 2; k++) begin
      set_spec(1, 1, 0, 16'(16'h0500 + k), 16'(16'h0400 + k));
      tick();
    end
    set_spec(0, 0, 0, 16'h0, 16'h0);
    chk("t5_count2", 32'(bus.count_o), 2);
    for (int i = 0; i < 10; i++) begin
      set_spec(1, 1, 0, 16'(16'h0500 + i + 2), 16'(16'h0400 + i + 2));
      set_res(1, 1, 16'h0);
      tick();
      chk($sformatf("t5_iter%0d_count", i), 32'(bus.count_o), 2);
      chk($sformatf("t5_iter%0d_redir", i), 32'(bus.redirect_v_o), 0);
    end
    chk("t5_brcnt", 32'(bus.branch_cnt_o), 15);
    // Same cycle with a mispredict: head is entry 10 (fall 0x040A)
    set_spec(1, 1, 0, 16'h050C, 16'h040C);
    set_res(1, 0, 16'h0);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(0, 0, 16'h0);
    chk("t5m_redir", 32'(bus.redirect_v_o), 1);
    chk("t5m_pc",    32'(bus.redirect_pc_o), 32'h040A);
    chk("t5m_count", 32'(bus.count_o), 0);
    chk("t5m_brcnt", 32'(bus.branch_cnt_o), 16);
    chk("t5m_mpcnt", 32'(bus.mispred_cnt_o), 4);
    tick();
    chk("t5m_count_after", 32'(bus.count_o), 0);

    // Resolve while empty
    set_res(1, 1, 16'h0);
    tick();
    set_res(0, 0, 16'h0);
    chk("t6_error",  32'(bus.error_o), 1);
    chk("t6_brcnt",  32'(bus.branch_cnt_o), 16);
    chk("t6_mpcnt",  32'(bus.mispred_cnt_o), 4);
    chk("t6_redir",  32'(bus.redirect_v_o), 0);
    tick();
    tick();
    chk("t6_error_sticky", 32'(bus.error_o), 1);

    // Reset mid-redirect
    set_spec(1, 0, 0, 16'h0777, 16'h0050);
    tick();
    set_spec(0, 0, 0, 16'h0, 16'h0);
    set_res(1, 1, 16'h0);
    tick();
    set_res(0, 0, 16'h0);
    chk("t7_redir", 32'(bus.redirect_v_o), 1);
    chk("t7_pc",    32'(bus.redirect_pc_o), 32'h0777);
    #2 reset_i = 1'b1;
    #1;
    chk_reset_state("t7_async");
    #2 reset_i = 1'b0;

    // Counter saturation (CNT_W=5 -> max 31)
    for (int i = 0; i < 33; i++) begin
      set_spec(1, 0, 0, 16'h0600, 16'h0601);
      tick();
      set_spec(0, 0, 0, 16'h0, 16'h0);
      set_res(1, 1, 16'h0);
      tick();
      set_res(0, 0, 16'h0);
      if (i == 29) begin
        chk("t8_brcnt30", 32'(bus.branch_cnt_o), 30);
        chk("t8_mpcnt30", 32'(bus.mispred_cnt_o), 30);
      end
      tick();
    end
    chk("t8_brcnt_sat", 32'(bus.branch_cnt_o), 31);
    chk("t8_mpcnt_sat", 32'(bus.mispred_cnt_o), 31);
    chk("t8_pc",        32'(bus.redirect_pc_o), 32'h0600);
    chk("t8_error",     32'(bus.error_o), 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Back-end counterpart to the front-end branch predictor. It records every speculative branch the FE issues (conditional branches and BX) in an in-order queue. It checks each one against the actual outcome produced by the execute stage. On a mispredict it drives a registered redirect and flush back to the FE, and it keeps saturating prediction-accuracy counters.

Parameters:
PC_W, 16, width of program counter and branch target
DEPTH, 4, number of outstanding speculative branches (power of 2, >=2)
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
spec_v_i  in  1  FE issues a speculative branch this cycle
spec_ready_o  out  1  queue can accept (not full); FE stalls when low
spec_taken_i  in  1  FE prediction (1 = taken)
spec_is_bx_i  in  1  branch is BX (target unknown at FE)
spec_target_pc_i  in  PC_W  predicted-taken target
spec_fall_pc_i  in  PC_W  fall-through PC (branch PC + 1)
resolve_v_i  in  1  EX resolves the oldest outstanding branch
resolve_taken_i  in  1  actual direction
resolve_target_i  in  PC_W  actual target (used for BX)
redirect_v_o  out  1  one-cycle pulse: FE must fetch from redirect_pc_o
redirect_pc_o  out  PC_W  corrected fetch PC
flush_o  out  1  one-cycle pulse, same cycle as redirect_v_o: squash younger wrong-path work
count_o  out  $clog2(DEPTH)+1  outstanding entries
branch_cnt_o  out  CNT_W  resolved-branch count, saturating
mispred_cnt_o  out  CNT_W  mispredict count, saturating
error_o  out  1  sticky: resolve while empty

Behaviour:
- Reset (async, any cycle, including mid-redirect): queue empty, count_o=0, spec_ready_o=1, redirect_v_o=0, redirect_pc_o=0, flush_o=0, both counters 0, error_o=0.
- Queue: circular FIFO with head/tail pointers plus one extra wrap bit each.
  - Entry fields: taken, is_bx, target_pc, fall_pc.
  - Push when spec_v_i && spec_ready_o. A spec_v_i while full is ignored; the FE must hold.
  - spec_ready_o = (count_o != DEPTH), purely combinational from state. There is no same-cycle pop-through.
- Resolution, in order, applied to the head entry when resolve_v_i && count_o != 0:
  - Non-BX: mispredict = (head.taken != resolve_taken_i). Correct PC = resolve_taken_i ? head.target_pc : head.fall_pc.
  - BX (always predicted not-taken): mispredict = resolve_taken_i || (head.taken && head.target_pc != resolve_target_i). Correct PC = resolve_target_i when taken, else head.fall_pc.
  - Every resolution pops the head and increments branch_cnt_o.
- On mispredict, the next cycle:
  - redirect_v_o=1, flush_o=1, redirect_pc_o = correct PC.
  - Queue cleared: head=tail, count 0. All younger entries are on the wrong path.
  - mispred_cnt_o increments.
  - redirect_pc_o holds its value until the next redirect.
- Correct prediction: pop only; no redirect.
- Latency: resolve to redirect_v_o is 1 cycle (registered).
- Simultaneous push and resolve in the same cycle:
  - Correct prediction: count unchanged, pointers both advance.
  - Mispredict: the flush overrides, and the pushed entry is discarded, since it is wrong-path.
- Redirect cycle: any spec_v_i or resolve_v_i is ignored, because the pipeline is squashing. The FE samples redirect_v_o the same cycle.
- Resolve while empty: no state change except error_o set sticky until reset. Counters are unaffected.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Wrap-around: pointers roll modulo DEPTH. Full/empty are distinguished by the wrap bit.
- State machine (2 states):
  - RUN -> REDIRECT on a mispredict resolution.
  - REDIRECT -> RUN unconditionally after 1 cycle.
  - redirect_v_o and flush_o are asserted only in REDIRECT.

Decomposition:
- Shared FE/BE package: branch entry struct (taken, is_bx, target_pc, fall_pc); branch type encoding constants (CC=00, B=01, BL=10, BX=11); PC_W default.
- Sub-module: branch_spec_fifo, a generic pointer-based FIFO with clear and count. The top level holds the compare logic, state machine and counters.

Test Plan:
- Push a CC branch (taken=1, target=0x0040, fall=0x0011), then resolve taken=1 -> no redirect; count 1->0; branch_cnt=1, mispred_cnt=0.
- Push a CC branch (taken=0, target=0x0080, fall=0x0021), resolve taken=1 -> redirect_v_o and flush_o pulse exactly 1 cycle after resolve; redirect_pc_o=0x0080; mispred_cnt=1.
- Push 4 entries -> spec_ready_o=0 and a 5th push is ignored. Resolve the oldest as a mispredict -> count_o=0 the cycle after, and all 4 entries are gone.
- Push a BX (taken=0, fall=0x0031), resolve taken=1 target=0x1234 -> redirect_pc_o=0x1234.
- Push and correct-resolve in the same cycle with count 2 -> count stays 2, and the pointers wrap correctly over 10 iterations. Repeat the same cycle with a mispredict -> the new entry is discarded and count_o=0.
- Resolve with the queue empty -> error_o=1 and stays 1. Assert reset_i mid-REDIRECT -> all outputs are 0 immediately, before the next edge.
